// File: rtl/bp_ptw_sv39.sv
// SV39 hardware page-table walker: turns a TLB miss into up to three PTE reads
// and returns a leaf translation or a page fault on the TLB fill port.
module bp_ptw_sv39 #(
    parameter int vaddr_width_p       = 39,
    parameter int paddr_width_p       = 56,
    parameter int page_offset_width_p = 12,
    parameter int pte_width_p         = 64
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic [paddr_width_p-page_offset_width_p-1:0] satp_ppn_i,
    input  logic                                      flush_i,
    input  logic                                      miss_v_i,
    input  logic [vaddr_width_p-page_offset_width_p-1:0] miss_vpn_i,
    output logic                                      miss_ready_o,
    output logic                                      mem_req_v_o,
    output logic [paddr_width_p-1:0]                  mem_req_addr_o,
    input  logic                                      mem_req_ready_i,
    input  logic                                      mem_resp_v_i,
    input  logic [pte_width_p-1:0]                    mem_resp_data_i,
    output logic                                      fill_v_o,
    output logic [vaddr_width_p-page_offset_width_p-1:0] fill_vpn_o,
    output logic [paddr_width_p-page_offset_width_p-1:0] fill_ppn_o,
    output logic [1:0]                                fill_level_o,
    output logic [3:0]                                fill_perm_o,
    output logic                                      fill_fault_o,
    input  logic                                      fill_yumi_i
);

    localparam int vpn_width_lp = vaddr_width_p - page_offset_width_p;
    localparam int ppn_width_lp = paddr_width_p - page_offset_width_p;
    localparam int seg_width_lp = 9;

    localparam logic [2:0] idle_s  = 3'd0;
    localparam logic [2:0] send_s  = 3'd1;
    localparam logic [2:0] wait_s  = 3'd2;
    localparam logic [2:0] drain_s = 3'd3;
    localparam logic [2:0] done_s  = 3'd4;

    logic [2:0]              state_r;
    logic                    live_r;
    logic [1:0]              level_r;
    logic [vpn_width_lp-1:0] vpn_r;
    logic [ppn_width_lp-1:0] base_r;
    logic [ppn_width_lp-1:0] fill_ppn_r;
    logic [1:0]              fill_level_r;
    logic [3:0]              fill_perm_r;
    logic                    fill_fault_r;

    logic [seg_width_lp-1:0] seg;
    logic [ppn_width_lp-1:0] pte_ppn;
    logic [ppn_width_lp-1:0] leaf_ppn;
    logic                    pte_v, pte_r, pte_w, pte_x, pte_u;
    logic                    pte_invalid, pte_leaf, misaligned;
    logic                    miss_accept;
    logic                    unused_pte_bits;

    assign pte_v   = mem_resp_data_i[0];
    assign pte_r   = mem_resp_data_i[1];
    assign pte_w   = mem_resp_data_i[2];
    assign pte_x   = mem_resp_data_i[3];
    assign pte_u   = mem_resp_data_i[4];
    assign pte_ppn = mem_resp_data_i[10 +: ppn_width_lp];
    assign unused_pte_bits = ^{mem_resp_data_i[pte_width_p-1:10+ppn_width_lp], mem_resp_data_i[7:5]};

    assign pte_invalid = ~pte_v | (pte_w & ~pte_r);
    assign pte_leaf    = pte_r | pte_x;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        seg        = vpn_r[0 +: seg_width_lp];
        misaligned = 1'b0;
        leaf_ppn   = pte_ppn;
        case (level_r)
            2'd1: begin
                seg        = vpn_r[seg_width_lp +: seg_width_lp];
                misaligned = |pte_ppn[seg_width_lp-1:0];
                leaf_ppn   = {pte_ppn[ppn_width_lp-1:seg_width_lp], vpn_r[seg_width_lp-1:0]};
            end
            2'd2: begin
                seg        = vpn_r[2*seg_width_lp +: seg_width_lp];
                misaligned = |pte_ppn[2*seg_width_lp-1:0];
                leaf_ppn   = {pte_ppn[ppn_width_lp-1:2*seg_width_lp], vpn_r[2*seg_width_lp-1:0]};
            end
            default: ;
        endcase
    end

    // live_r keeps the miss port closed until the first clock after reset release.
    assign miss_ready_o = live_r & (state_r == idle_s);
    assign miss_accept  = miss_ready_o & miss_v_i & ~flush_i;

    assign mem_req_v_o    = (state_r == send_s) & ~flush_i;
    assign mem_req_addr_o = mem_req_v_o
                          ? ({base_r, {page_offset_width_p{1'b0}}} + (paddr_width_p'(seg) << 3))
                          : '0;

    assign fill_v_o     = (state_r == done_s);
    assign fill_vpn_o   = fill_v_o ? vpn_r        : '0;
    assign fill_ppn_o   = fill_v_o ? fill_ppn_r   : '0;
    assign fill_level_o = fill_v_o ? fill_level_r : '0;
    assign fill_perm_o  = fill_v_o ? fill_perm_r  : '0;
    assign fill_fault_o = fill_v_o ? fill_fault_r : 1'b0;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    // NOTE: datapath registers are reset too, because every output must read 0 out of reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= idle_s;
            live_r       <= 1'b0;
            level_r      <= '0;
            vpn_r        <= '0;
            base_r       <= '0;
            fill_ppn_r   <= '0;
            fill_level_r <= '0;
            fill_perm_r  <= '0;
            fill_fault_r <= 1'b0;
        end else begin
            live_r <= 1'b1;
            case (state_r)
                idle_s: begin
                    if (miss_accept) begin
                        vpn_r   <= miss_vpn_i;
                        level_r <= 2'd2;
                        base_r  <= satp_ppn_i;
                        state_r <= send_s;
                    end
                end
                send_s: begin
                    if (flush_i)              state_r <= idle_s;
                    else if (mem_req_ready_i) state_r <= wait_s;
                end
                wait_s: begin
                    if (flush_i) begin
                        // A response landing with the flush is dropped right here.
                        state_r <= mem_resp_v_i ? idle_s : drain_s;
                    end else if (mem_resp_v_i) begin
                        fill_ppn_r   <= '0;
                        fill_level_r <= '0;
                        fill_perm_r  <= '0;
                        fill_fault_r <= 1'b1;
                        state_r      <= done_s;
                        if (!pte_invalid && pte_leaf && !misaligned) begin
                            fill_ppn_r   <= leaf_ppn;
                            fill_level_r <= level_r;
                            fill_perm_r  <= {pte_u, pte_x, pte_w, pte_r};
                            fill_fault_r <= 1'b0;
                        end else if (!pte_invalid && !pte_leaf && level_r != 2'd0) begin
                            level_r <= level_r - 2'd1;
                            base_r  <= pte_ppn;
                            state_r <= send_s;
                        end
                    end
                end
                drain_s: begin
                    if (mem_resp_v_i) state_r <= idle_s;
                end
                done_s: begin
                    if (flush_i || fill_yumi_i) state_r <= idle_s;
                end
                default: state_r <= idle_s;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_ptw_sv39.sv
// Directed bench for bp_ptw_sv39: a PTE memory model answers requests while a
// monitor checks request addresses and fills against scoreboard queues.
module tb_bp_ptw_sv39;

    typedef struct packed {
        logic [26:0] vpn;
        logic [43:0] ppn;
        logic [1:0]  level;
        logic [3:0]  perm;
        logic        fault;
    } fill_t;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic [43:0] satp_ppn_i = 44'h80;
    logic        flush_i = 1'b0;
    logic        miss_v_i = 1'b0;
    logic [26:0] miss_vpn_i = '0;
    logic        miss_ready_o;
    logic        mem_req_v_o;
    logic [55:0] mem_req_addr_o;
    logic        mem_req_ready_i = 1'b1;
    logic        mem_resp_v_i = 1'b0;
    logic [63:0] mem_resp_data_i = '0;
    logic        fill_v_o;
    logic [26:0] fill_vpn_o;
    logic [43:0] fill_ppn_o;
    logic [1:0]  fill_level_o;
    logic [3:0]  fill_perm_o;
    logic        fill_fault_o;
    logic        fill_yumi_i = 1'b1;

    int total = 0;
    int bad   = 0;
    int resp_delay = 0;

    logic [63:0] mem [logic [55:0]];
    logic [55:0] exp_addr_q [$];
    fill_t       exp_fill_q [$];

    localparam logic [26:0] vpn_a = {9'h001, 9'h002, 9'h003};

    bp_ptw_sv39 dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .satp_ppn_i(satp_ppn_i), .flush_i(flush_i),
        .miss_v_i(miss_v_i), .miss_vpn_i(miss_vpn_i), .miss_ready_o(miss_ready_o),
        .mem_req_v_o(mem_req_v_o), .mem_req_addr_o(mem_req_addr_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_resp_v_i(mem_resp_v_i), .mem_resp_data_i(mem_resp_data_i),
        .fill_v_o(fill_v_o), .fill_vpn_o(fill_vpn_o), .fill_ppn_o(fill_ppn_o),
        .fill_level_o(fill_level_o), .fill_perm_o(fill_perm_o), .fill_fault_o(fill_fault_o),
        .fill_yumi_i(fill_yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_lookup(input logic [55:0] a);
        if (mem.exists(a)) return mem[a];
        return 64'h0;
    endfunction

    // Memory model: answers each accepted request resp_delay cycles after a 1-cycle base latency.
    initial begin
        logic [55:0] a;
        forever begin
            @(negedge clk_i);
            if (reset_n_i && mem_req_v_o && mem_req_ready_i) begin
                a = mem_req_addr_o;
                @(posedge clk_i);
                repeat (resp_delay) @(posedge clk_i);
                #1;
                mem_resp_v_i    = 1'b1;
                mem_resp_data_i = mem_lookup(a);
                @(posedge clk_i);
                #1;
                mem_resp_v_i    = 1'b0;
                mem_resp_data_i = '0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT hands over a request or a fill.
    initial begin
        logic [55:0] ea;
        fill_t       ef;
        forever begin
            @(negedge clk_i);
            if (reset_n_i && mem_req_v_o && mem_req_ready_i) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_req_addr", {8'h0, mem_req_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    ea = exp_addr_q.pop_front();
                    check("req_addr", {8'h0, mem_req_addr_o}, {8'h0, ea});
                end
            end
            if (reset_n_i && fill_v_o && fill_yumi_i) begin
                if (exp_fill_q.size() == 0) begin
                    check("unexpected_fill", {37'h0, fill_vpn_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    ef = exp_fill_q.pop_front();
                    check("fill_fault", {63'h0, fill_fault_o}, {63'h0, ef.fault});
                    check("fill_vpn", {37'h0, fill_vpn_o}, {37'h0, ef.vpn});
                    if (!ef.fault) begin
                        check("fill_ppn", {20'h0, fill_ppn_o}, {20'h0, ef.ppn});
                        check("fill_level", {62'h0, fill_level_o}, {62'h0, ef.level});
                        check("fill_perm", {60'h0, fill_perm_o}, {60'h0, ef.perm});
                    end
                end
            end
        end
    end

    task automatic push_fill(input logic [43:0] ppn, input logic [1:0] level,
                             input logic [3:0] perm, input logic fault);
        fill_t f;
        f.vpn = vpn_a; f.ppn = ppn; f.level = level; f.perm = perm; f.fault = fault;
        exp_fill_q.push_back(f);
    endtask

    task automatic setup_4k();
        mem.delete();
        mem[56'h80008] = 64'h20401;
        mem[56'h81010] = 64'h20801;
        mem[56'h82018] = (64'h12345 << 10) | 64'hCF;
    endtask

    task automatic do_miss(input logic [26:0] vpn);
        int n = 0;
        @(negedge clk_i);
        while (!miss_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("miss_ready_before_miss", {63'h0, miss_ready_o}, 64'h1);
        miss_vpn_i = vpn;
        miss_v_i   = 1'b1;
        @(posedge clk_i);
        #1;
        miss_v_i   = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(exp_addr_q.size() == 0 && exp_fill_q.size() == 0 && miss_ready_o) && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL walk_timeout: addr_left=%0d fill_left=%0d", exp_addr_q.size(), exp_fill_q.size());
            exp_addr_q.delete();
            exp_fill_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int n;
        // Reset state.
        #12;
        check("rst_miss_ready", {63'h0, miss_ready_o}, 64'h0);
        check("rst_req_v", {63'h0, mem_req_v_o}, 64'h0);
        check("rst_fill_v", {63'h0, fill_v_o}, 64'h0);
        check("rst_req_addr", {8'h0, mem_req_addr_o}, 64'h0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_miss_ready", {63'h0, miss_ready_o}, 64'h1);

        // 4KiB walk.
        setup_4k();
        exp_addr_q.push_back(56'h80008);
        exp_addr_q.push_back(56'h81010);
        exp_addr_q.push_back(56'h82018);
        push_fill(44'h12345, 2'd0, 4'h7, 1'b0);
        do_miss(vpn_a);
        wait_done();

        // 2MiB superpage.
        setup_4k();
        mem[56'h81010] = (64'h200 << 10) | 64'h0B;
        exp_addr_q.push_back(56'h80008);
        exp_addr_q.push_back(56'h81010);
        push_fill(44'h203, 2'd1, 4'h5, 1'b0);
        do_miss(vpn_a);
        wait_done();

        // Misaligned superpage.
        setup_4k();
        mem[56'h81010] = (64'h201 << 10) | 64'h0B;
        exp_addr_q.push_back(56'h80008);
        exp_addr_q.push_back(56'h81010);
        push_fill(44'h0, 2'd0, 4'h0, 1'b1);
        do_miss(vpn_a);
        wait_done();

        // Invalid level-2 PTE.
        setup_4k();
        mem[56'h80008] = 64'h0;
        exp_addr_q.push_back(56'h80008);
        push_fill(44'h0, 2'd0, 4'h0, 1'b1);
        do_miss(vpn_a);
        wait_done();

        // W without R.
        setup_4k();
        mem[56'h80008] = 64'h5;
        exp_addr_q.push_back(56'h80008);
        push_fill(44'h0, 2'd0, 4'h0, 1'b1);
        do_miss(vpn_a);
        wait_done();

        // Pointer at level 0.
        setup_4k();
        mem[56'h82018] = 64'h20801;
        exp_addr_q.push_back(56'h80008);
        exp_addr_q.push_back(56'h81010);
        exp_addr_q.push_back(56'h82018);
        push_fill(44'h0, 2'd0, 4'h0, 1'b1);
        do_miss(vpn_a);
        wait_done();

        // Backpressure on both the request and the fill side.
        setup_4k();
        @(posedge clk_i);
        #1;
        mem_req_ready_i = 1'b0;
        fill_yumi_i     = 1'b0;
        exp_addr_q.push_back(56'h80008);
        exp_addr_q.push_back(56'h81010);
        exp_addr_q.push_back(56'h82018);
        push_fill(44'h12345, 2'd0, 4'h7, 1'b0);
        do_miss(vpn_a);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_req_v", {63'h0, mem_req_v_o}, 64'h1);
            check("bp_req_addr", {8'h0, mem_req_addr_o}, 64'h80008);
            check("bp_miss_ready", {63'h0, miss_ready_o}, 64'h0);
        end
        @(posedge clk_i);
        #1;
        mem_req_ready_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!fill_v_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk_i);
            check("bp_fill_v", {63'h0, fill_v_o}, 64'h1);
            check("bp_fill_ppn", {20'h0, fill_ppn_o}, 64'h12345);
            check("bp_fill_perm", {60'h0, fill_perm_o}, 64'h7);
            check("bp_fill_miss_ready", {63'h0, miss_ready_o}, 64'h0);
        end
        @(posedge clk_i);
        #1;
        fill_yumi_i = 1'b1;
        wait_done();

        // Flush while waiting for the first response; that response comes 3 cycles later.
        setup_4k();
        resp_delay = 3;
        exp_addr_q.push_back(56'h80008);
        do_miss(vpn_a);
        n = 0;
        @(negedge clk_i);
        while (!(mem_req_v_o && mem_req_ready_i) && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("drain_miss_ready", {63'h0, miss_ready_o}, 64'h0);
            check("drain_fill_v", {63'h0, fill_v_o}, 64'h0);
        end
        @(negedge clk_i);
        check("after_drain_miss_ready", {63'h0, miss_ready_o}, 64'h1);
        resp_delay = 0;
        wait_done();

        // A walk after the flush completes normally.
        setup_4k();
        exp_addr_q.push_back(56'h80008);
        exp_addr_q.push_back(56'h81010);
        exp_addr_q.push_back(56'h82018);
        push_fill(44'h12345, 2'd0, 4'h7, 1'b0);
        do_miss(vpn_a);
        wait_done();

        // Asynchronous reset in the middle of SEND.
        setup_4k();
        @(posedge clk_i);
        #1;
        mem_req_ready_i = 1'b0;
        do_miss(vpn_a);
        @(negedge clk_i);
        check("pre_rst_req_v", {63'h0, mem_req_v_o}, 64'h1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("async_rst_req_v", {63'h0, mem_req_v_o}, 64'h0);
        check("async_rst_req_addr", {8'h0, mem_req_addr_o}, 64'h0);
        check("async_rst_miss_ready", {63'h0, miss_ready_o}, 64'h0);
        check("async_rst_fill_v", {63'h0, fill_v_o}, 64'h0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        mem_req_ready_i = 1'b1;
        @(negedge clk_i);
        check("rst_release_miss_ready", {63'h0, miss_ready_o}, 64'h1);

        // Walk after reset.
        exp_addr_q.push_back(56'h80008);
        exp_addr_q.push_back(56'h81010);
        exp_addr_q.push_back(56'h82018);
        push_fill(44'h12345, 2'd0, 4'h7, 1'b0);
        do_miss(vpn_a);
        wait_done();

        repeat (3) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
